// File: rtl/fifo_cfg_pkg.sv
// fifo_cfg_pkg: shared full-policy type and default threshold constants for fifo_prog
package fifo_cfg_pkg;

    typedef enum logic {FIFO_DROP, FIFO_OVERWRITE} fifo_mode_e;

    localparam int DEF_AE_THRESH = 2;
    localparam int DEF_AF_MARGIN = 2;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port RAM, one write port and one synchronous read port, no reset
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // write and registered read; a same-address read returns the old word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog: synchronous FIFO with programmable thresholds, occupancy count, drop/overwrite policy and sticky errors
module fifo_prog
    import fifo_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 1 << ADDR_WIDTH,
    parameter int AF_THRESH  = FIFO_DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  mode,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  wrap_on_full,
    output logic                  overflow,
    output logic                  underflow
);

    if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH &&
          FIFO_DEPTH == (1 << ADDR_WIDTH))) begin : g_bad_cfg
        $error("fifo_prog: illegal threshold or depth configuration");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rd_valid_q, rd_valid_d, wrap_q, wrap_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  loaded_q, loaded_d;
    logic                  rd_ok, wr_ok, ovw, drop, mem_we;
    logic [DATA_WIDTH-1:0] mem_q;

    assign empty        = count_q == '0;
    assign full         = count_q == DEPTH_C;
    assign almost_full  = count_q >= AF_C;
    assign almost_empty = count_q <= AE_C;
    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign wrap_on_full = wrap_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    // the RAM read register has no reset, so data_out shows zero until the first accepted read
    assign data_out     = loaded_q ? mem_q : '0;

    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rd_ptr_q),
        .rdata (mem_q)
    );

    // request acceptance, overwrite/drop policy and next-state computation
    always_comb begin
        rd_ok      = rd_en && !empty;
        wr_ok      = wr_en && (!full || rd_ok);
        ovw        = wr_en && full && !rd_ok && fifo_mode_e'(mode) == FIFO_OVERWRITE;
        drop       = wr_en && full && !rd_ok && fifo_mode_e'(mode) == FIFO_DROP;
        mem_we     = wr_ok || ovw;
        wr_ptr_d   = mem_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = (rd_ok || ovw) ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = (wr_ok && !rd_ok) ? count_q + 1'b1 :
                     (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
        rd_valid_d = rd_ok;
        wrap_d     = ovw;
        loaded_d   = loaded_q || rd_ok;
        ovf_d      = drop || (ovf_q && !clr_err);
        udf_d      = (rd_en && empty) || (udf_q && !clr_err);
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            wrap_q     <= 1'b0;
            loaded_q   <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            wrap_q     <= wrap_d;
            loaded_q   <= loaded_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog: scoreboard bench for fifo_prog (depth 4, AF 3, AE 1) against a queue-based model
module tb_fifo_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0, mode = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, wrap_on_full, overflow, underflow;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_dout = '0;
    bit m_rdv = 0, m_wrap = 0, m_ovf = 0, m_udf = 0;

    fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .mode         (mode),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .wrap_on_full (wrap_on_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compare every registered output with the model, pop the scoreboard on rd_valid
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", int'(count), m_q.size());
            chk("full", int'(full), int'(m_q.size() == 4));
            chk("empty", int'(empty), int'(m_q.size() == 0));
            chk("almost_full", int'(almost_full), int'(m_q.size() >= 3));
            chk("almost_empty", int'(almost_empty), int'(m_q.size() <= 1));
            chk("rd_valid", int'(rd_valid), int'(m_rdv));
            chk("wrap_on_full", int'(wrap_on_full), int'(m_wrap));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_udf));
            chk("data_hold", int'(data_out), int'(m_dout));
            if (rd_valid && exp_q.size() > 0) chk("scoreboard_data", int'(data_out), int'(exp_q.pop_front()));
        end
    end

    // one clock of stimulus; the model applies the FIFO rules to the queue at the same edge
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit md, input bit c);
        int sz;
        bit rok;
        wr_en = w; data_in = d; rd_en = r; mode = md; clr_err = c;
        @(posedge clk);
        sz = m_q.size();
        rok = r && sz > 0;
        m_rdv = rok;
        m_wrap = 0;
        if (c) begin m_ovf = 0; m_udf = 0; end
        if (r && sz == 0) m_udf = 1;
        if (rok) begin m_dout = m_q.pop_front(); exp_q.push_back(m_dout); end
        if (w) begin
            if (sz < 4 || rok) m_q.push_back(d);
            else if (md) begin void'(m_q.pop_front()); m_q.push_back(d); m_wrap = 1; end
            else m_ovf = 1;
        end
        #1;
        wr_en = 0; rd_en = 0; clr_err = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_wrap", int'(wrap_on_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 check_reset_values();
        m_q.delete(); exp_q.delete();
        m_dout = '0; m_rdv = 0; m_wrap = 0; m_ovf = 0; m_udf = 0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 4; i++) step(1, base + 8'(i), 0, 0, 0);
    endtask

    initial begin
        logic [7:0] t1 [3];
        logic [7:0] t3 [4];
        t1 = '{8'h11, 8'h22, 8'h33};
        t3 = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
        #1 check_reset_values();
        #11 rst = 1'b0;

        for (int i = 0; i < 3; i++) step(1, t1[i], 0, 0, 0);
        chk("t1_count", int'(count), 3);
        chk("t1_almost_full", int'(almost_full), 1);
        chk("t1_full", int'(full), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            chk("t1_data", int'(data_out), int'(t1[i]));
            chk("t1_rd_valid", int'(rd_valid), 1);
        end
        chk("t1_empty", int'(empty), 1);

        fill(8'hA0);
        step(1, 8'hFF, 0, 0, 0);
        chk("t2_overflow", int'(overflow), 1);
        chk("t2_count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            chk("t2_data", int'(data_out), 'hA0 + i);
        end
        step(0, 0, 0, 0, 1);
        chk("t2_clr", int'(overflow), 0);

        fill(8'hA0);
        step(1, 8'hB0, 0, 1, 0);
        chk("t3_wrap", int'(wrap_on_full), 1);
        chk("t3_count", int'(count), 4);
        chk("t3_no_overflow", int'(overflow), 0);
        step(0, 0, 0, 1, 0);
        chk("t3_wrap_pulse", int'(wrap_on_full), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            chk("t3_data", int'(data_out), int'(t3[i]));
        end

        step(0, 0, 1, 0, 0);
        chk("t4_underflow", int'(underflow), 1);
        chk("t4_rd_valid", int'(rd_valid), 0);
        chk("t4_data_hold", int'(data_out), 'hB0);
        step(0, 0, 0, 0, 1);
        chk("t4_clr", int'(underflow), 0);

        fill(8'hC0);
        for (int i = 0; i < 8; i++) begin
            step(1, 8'hD0 + 8'(i), 1, i[0], 0);
            chk("t5_count", int'(count), 4);
            chk("t5_data", int'(data_out), i < 4 ? 'hC0 + i : 'hD0 + i - 4);
        end
        chk("t5_no_err", int'(overflow | underflow), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

        step(1, 8'h01, 1, 0, 0);
        chk("empty_rw_count", int'(count), 1);
        chk("empty_rw_underflow", int'(underflow), 1);
        step(0, 0, 1, 0, 1);
        chk("empty_rw_data", int'(data_out), 1);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
                 1'($urandom), $urandom_range(0, 99) < 8);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);

        for (int i = 0; i < 3; i++) step(1, 8'h70 + 8'(i), 0, 0, 0);
        async_reset();
        step(1, 8'h5A, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("t6_data", int'(data_out), 'h5A);

        @(negedge clk);
        #1 chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
